hd63701_irq2_ctrl: RTL and testbench

HD63701_IRQ2_CTRL -- requirements
Module: hd63701_irq2_ctrl

---
 rtl/hd63701_irq2_ctrl.sv | 134 +++++++++++++
 tb/tb_hd63701_irq2_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hd63701_irq2_ctrl.sv
// HD63701 IRQ2 source controller: timer (TCSR) and SCI (TRCSR) status flags with read-then-access clear.
// Optional SCI interrupt logic is built only when HD63701_IRQ2_SCI_EN is defined.
module hd63701_irq2_ctrl (
    input  logic        CLKx2,
    input  logic        RST,
    input  logic        CE,
    input  logic [15:0] AD,
    input  logic        RW,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        DSEL,
    input  logic        TIM_ICF_SET,
    input  logic        TIM_OCF_SET,
    input  logic        TIM_TOF_SET,
    input  logic        SCI_RDRF_SET,
    input  logic        SCI_ORFE_SET,
    input  logic        SCI_TDRE,
    output logic        IRQ2_TIM,
    output logic        IRQ2_SCI
);

    localparam logic [15:0] A_TCSR   = 16'h0008;
    localparam logic [15:0] A_FRC_HI = 16'h0009;
    localparam logic [15:0] A_OCR_HI = 16'h000B;
    localparam logic [15:0] A_OCR_LO = 16'h000C;
    localparam logic [15:0] A_ICR_HI = 16'h000D;
    localparam logic [15:0] A_TRCSR  = 16'h0011;
    localparam logic [15:0] A_RDR    = 16'h0012;

    // Returns {flag, arm}. A set pulse beats a same-cycle clear; the arm is only
    // taken from flags already set when the status register is read.
    function automatic logic [1:0] flag_next(input logic flag, input logic arm, input logic set,
                                             input logic clr_acc, input logic stat_rd);
        logic hit;
        hit = clr_acc & arm;
        if (set) begin
            return {1'b1, ~hit & (arm | (stat_rd & flag))};
        end else if (hit) begin
            return 2'b00;
        end else begin
            return {flag, arm | (stat_rd & flag)};
        end
    endfunction

    logic       rd_s, wr_s;
    logic       rd_tcsr_s, wr_tcsr_s, rd_frc_s, wr_ocr_s, rd_icr_s;
    logic       icf_r, ocf_r, tof_r;
    logic       arm_icf_r, arm_ocf_r, arm_tof_r;
    logic [4:0] tcsr_ctl_r;
    logic [7:0] tcsr_s, trcsr_s;
    logic       unused_do_s;

    assign rd_s      = CE & RW;
    assign wr_s      = CE & ~RW;
    assign rd_tcsr_s = rd_s & (AD == A_TCSR);
    assign wr_tcsr_s = wr_s & (AD == A_TCSR);
    assign rd_frc_s  = rd_s & (AD == A_FRC_HI);
    assign wr_ocr_s  = wr_s & ((AD == A_OCR_HI) | (AD == A_OCR_LO));
    assign rd_icr_s  = rd_s & (AD == A_ICR_HI);
    assign unused_do_s = &{1'b0, DO[7:5]};

    // Timer flags, their clear arms and TCSR control bits.
    always_ff @(posedge CLKx2) begin
        if (RST) begin
            {icf_r, arm_icf_r} <= 2'b00;
            {ocf_r, arm_ocf_r} <= 2'b00;
            {tof_r, arm_tof_r} <= 2'b00;
            tcsr_ctl_r         <= 5'b00000;
        end else begin
            {icf_r, arm_icf_r} <= flag_next(icf_r, arm_icf_r, TIM_ICF_SET, rd_icr_s, rd_tcsr_s);
            {ocf_r, arm_ocf_r} <= flag_next(ocf_r, arm_ocf_r, TIM_OCF_SET, wr_ocr_s, rd_tcsr_s);
            {tof_r, arm_tof_r} <= flag_next(tof_r, arm_tof_r, TIM_TOF_SET, rd_frc_s, rd_tcsr_s);
            if (wr_tcsr_s) begin
                tcsr_ctl_r <= DO[4:0];
            end else begin
                tcsr_ctl_r <= tcsr_ctl_r;
            end
        end
    end

    assign tcsr_s   = {icf_r, ocf_r, tof_r, tcsr_ctl_r};
    assign IRQ2_TIM = (icf_r & tcsr_ctl_r[4]) | (ocf_r & tcsr_ctl_r[3]) | (tof_r & tcsr_ctl_r[2]);

`ifdef HD63701_IRQ2_SCI_EN
    logic       rd_trcsr_s, wr_trcsr_s, rd_rdr_s;
    logic       rdrf_r, orfe_r, arm_rdrf_r, arm_orfe_r;
    logic [4:0] trcsr_ctl_r;

    assign rd_trcsr_s = rd_s & (AD == A_TRCSR);
    assign wr_trcsr_s = wr_s & (AD == A_TRCSR);
    assign rd_rdr_s   = rd_s & (AD == A_RDR);

    // SCI receive flags, their clear arms and TRCSR control bits.
    always_ff @(posedge CLKx2) begin
        if (RST) begin
            {rdrf_r, arm_rdrf_r} <= 2'b00;
            {orfe_r, arm_orfe_r} <= 2'b00;
            trcsr_ctl_r          <= 5'b00000;
        end else begin
            {rdrf_r, arm_rdrf_r} <= flag_next(rdrf_r, arm_rdrf_r, SCI_RDRF_SET, rd_rdr_s, rd_trcsr_s);
            {orfe_r, arm_orfe_r} <= flag_next(orfe_r, arm_orfe_r, SCI_ORFE_SET, rd_rdr_s, rd_trcsr_s);
            if (wr_trcsr_s) begin
                trcsr_ctl_r <= DO[4:0];
            end else begin
                trcsr_ctl_r <= trcsr_ctl_r;
            end
        end
    end

    assign trcsr_s  = {rdrf_r, orfe_r, SCI_TDRE, trcsr_ctl_r};
    assign IRQ2_SCI = ((rdrf_r | orfe_r) & trcsr_ctl_r[4]) | (SCI_TDRE & trcsr_ctl_r[2]);
`else
    logic unused_sci_s;
    assign unused_sci_s = &{1'b0, SCI_RDRF_SET, SCI_ORFE_SET, A_RDR};
    assign trcsr_s      = {2'b00, SCI_TDRE, 5'b00000};
    assign IRQ2_SCI     = 1'b0;
`endif

    // Read-data mux; DI is forced to zero whenever this block is not selected.
    always_comb begin
        DSEL = RW & ((AD == A_TCSR) | (AD == A_TRCSR));
        DI   = 8'h00;
        if (DSEL) begin
            case (AD)
                A_TCSR:  DI = tcsr_s;
                A_TRCSR: DI = trcsr_s;
                default: DI = 8'h00;
            endcase
        end else begin
            DI = 8'h00;
        end
    end

endmodule

// File: tb/tb_hd63701_irq2_ctrl.sv
// Self-checking bench for hd63701_irq2_ctrl: directed scenarios plus randomized traffic
// compared against a flag/arm reference model. Honours HD63701_IRQ2_SCI_EN.
module tb_hd63701_irq2_ctrl;

    logic        CLKx2 = 1'b0;
    logic        RST = 1'b0, CE = 1'b0, RW = 1'b1;
    logic [15:0] AD = 16'h0000;
    logic [7:0]  DO = 8'h00;
    logic [7:0]  DI;
    logic        DSEL;
    logic        TIM_ICF_SET = 1'b0, TIM_OCF_SET = 1'b0, TIM_TOF_SET = 1'b0;
    logic        SCI_RDRF_SET = 1'b0, SCI_ORFE_SET = 1'b0, SCI_TDRE = 1'b0;
    logic        IRQ2_TIM, IRQ2_SCI;

    int checks = 0;
    int errors = 0;

`ifdef HD63701_IRQ2_SCI_EN
    localparam bit SCI_EN = 1'b1;
`else
    localparam bit SCI_EN = 1'b0;
`endif

    hd63701_irq2_ctrl dut (
        .CLKx2(CLKx2), .RST(RST), .CE(CE), .AD(AD), .RW(RW), .DO(DO), .DI(DI), .DSEL(DSEL),
        .TIM_ICF_SET(TIM_ICF_SET), .TIM_OCF_SET(TIM_OCF_SET), .TIM_TOF_SET(TIM_TOF_SET),
        .SCI_RDRF_SET(SCI_RDRF_SET), .SCI_ORFE_SET(SCI_ORFE_SET), .SCI_TDRE(SCI_TDRE),
        .IRQ2_TIM(IRQ2_TIM), .IRQ2_SCI(IRQ2_SCI)
    );

    always #5 CLKx2 = ~CLKx2;

    // Reference model: flag index 0 ICF, 1 OCF, 2 TOF, 3 RDRF, 4 ORFE.
    bit       mflag [5];
    bit       marm  [5];
    bit [4:0] mtctl, mtrctl;

    function automatic bit clears(int i, bit rw, logic [15:0] ad);
        case (i)
            0:       return rw && ad == 16'h000D;
            1:       return !rw && (ad == 16'h000B || ad == 16'h000C);
            2:       return rw && ad == 16'h0009;
            default: return rw && ad == 16'h0012;
        endcase
    endfunction

    function automatic logic [15:0] status_addr(int i);
        return (i < 3) ? 16'h0008 : 16'h0011;
    endfunction

    function automatic logic [7:0] exp_tcsr();
        return {mflag[0], mflag[1], mflag[2], mtctl};
    endfunction

    function automatic logic [7:0] exp_trcsr();
        return SCI_EN ? {mflag[3], mflag[4], SCI_TDRE, mtrctl} : {2'b00, SCI_TDRE, 5'b00000};
    endfunction

    function automatic logic exp_irq_tim();
        return (mflag[0] & mtctl[4]) | (mflag[1] & mtctl[3]) | (mflag[2] & mtctl[2]);
    endfunction

    function automatic logic exp_irq_sci();
        return SCI_EN & (((mflag[3] | mflag[4]) & mtrctl[4]) | (SCI_TDRE & mtrctl[2]));
    endfunction

    task automatic model_step();
        bit       nf [5];
        bit       na [5];
        bit [4:0] sets;
        bit       hit, stat;
        sets = {SCI_ORFE_SET, SCI_RDRF_SET, TIM_TOF_SET, TIM_OCF_SET, TIM_ICF_SET};
        if (RST) begin
            for (int i = 0; i < 5; i++) begin mflag[i] = 0; marm[i] = 0; end
            mtctl = 0; mtrctl = 0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                nf[i] = mflag[i]; na[i] = marm[i];
                if (i < 3 || SCI_EN) begin
                    hit  = CE && clears(i, RW, AD) && marm[i];
                    stat = CE && RW && AD == status_addr(i) && mflag[i];
                    nf[i] = sets[i] ? 1'b1 : (hit ? 1'b0 : mflag[i]);
                    na[i] = hit ? 1'b0 : (marm[i] | stat);
                end
            end
            for (int i = 0; i < 5; i++) begin mflag[i] = nf[i]; marm[i] = na[i]; end
            if (CE && !RW && AD == 16'h0008) mtctl = DO[4:0];
            if (SCI_EN && CE && !RW && AD == 16'h0011) mtrctl = DO[4:0];
        end
    endtask

    task automatic drive(input bit ce, input logic [15:0] ad, input bit rw, input logic [7:0] d,
                         input logic [4:0] s, input bit rst);
        CE = ce; AD = ad; RW = rw; DO = d; RST = rst;
        {SCI_ORFE_SET, SCI_RDRF_SET, TIM_TOF_SET, TIM_OCF_SET, TIM_ICF_SET} = s;
    endtask

    task automatic tick();
        @(posedge CLKx2);
        model_step();
        #1;
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 5'b00000, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h0008, 1'b0, 8'hFF, 5'b11111, 1'b1);
        tick();
        drive(1'b1, 16'h0008, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DI !== 8'h00) begin errors++; $display("FAIL reset_tcsr DI=%h exp=00", DI); end
        checks++; if (IRQ2_TIM !== 1'b0 || IRQ2_SCI !== 1'b0) begin
            errors++; $display("FAIL reset_irq tim=%b sci=%b exp=0/0", IRQ2_TIM, IRQ2_SCI); end
        tick();
        drive(1'b1, 16'h0009, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DSEL !== 1'b0 || DI !== 8'h00) begin
            errors++; $display("FAIL nosel DSEL=%b DI=%h exp=0/00", DSEL, DI); end
        tick();
    endtask

    task automatic test_tcsr_write();
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 5'b00000, 1'b1); tick();
        drive(1'b1, 16'h0008, 1'b0, 8'hFF, 5'b00000, 1'b0); tick();
        drive(1'b1, 16'h0008, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DI !== 8'h1F || DSEL !== 1'b1 || IRQ2_TIM !== 1'b0) begin
            errors++; $display("FAIL tcsr_wr DI=%h DSEL=%b IRQ=%b exp=1f/1/0", DI, DSEL, IRQ2_TIM); end
        tick();
    endtask

    task automatic test_ocf_clear();
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 5'b00000, 1'b1); tick();
        drive(1'b1, 16'h0008, 1'b0, 8'h08, 5'b00000, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 5'b00010, 1'b0); tick();
        drive(1'b1, 16'h0008, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DI !== 8'h48 || IRQ2_TIM !== 1'b1) begin
            errors++; $display("FAIL ocf_set DI=%h IRQ=%b exp=48/1", DI, IRQ2_TIM); end
        tick();
        drive(1'b1, 16'h000B, 1'b0, 8'h55, 5'b00000, 1'b0); tick();
        drive(1'b1, 16'h0008, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DI !== 8'h08 || IRQ2_TIM !== 1'b0) begin
            errors++; $display("FAIL ocf_clr DI=%h IRQ=%b exp=08/0", DI, IRQ2_TIM); end
        tick();
    endtask

    task automatic test_tof_icf();
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 5'b00000, 1'b1); tick();
        drive(1'b1, 16'h0008, 1'b0, 8'h14, 5'b00100, 1'b0); tick();
        drive(1'b1, 16'h0008, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DI !== 8'h34 || IRQ2_TIM !== 1'b1) begin
            errors++; $display("FAIL tof_set DI=%h IRQ=%b exp=34/1", DI, IRQ2_TIM); end
        tick();
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 5'b00001, 1'b0); tick();
        drive(1'b1, 16'h0009, 1'b1, 8'h00, 5'b00000, 1'b0); tick();
        drive(1'b1, 16'h000D, 1'b1, 8'h00, 5'b00000, 1'b0); tick();
        drive(1'b1, 16'h0008, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DI !== 8'h94 || IRQ2_TIM !== 1'b1) begin
            errors++; $display("FAIL tof_clr_icf_kept DI=%h IRQ=%b exp=94/1", DI, IRQ2_TIM); end
        tick();
        drive(1'b1, 16'h000D, 1'b1, 8'h00, 5'b00000, 1'b0); tick();
        @(negedge CLKx2);
        checks++; if (IRQ2_TIM !== 1'b0) begin
            errors++; $display("FAIL icf_clr IRQ=%b exp=0", IRQ2_TIM); end
    endtask

    task automatic test_set_wins();
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 5'b00000, 1'b1); tick();
        drive(1'b1, 16'h0008, 1'b0, 8'h04, 5'b00100, 1'b0); tick();
        drive(1'b1, 16'h0008, 1'b1, 8'h00, 5'b00000, 1'b0); tick();
        drive(1'b1, 16'h0009, 1'b1, 8'h00, 5'b00100, 1'b0); tick();
        @(negedge CLKx2);
        checks++; if (IRQ2_TIM !== 1'b1) begin errors++; $display("FAIL set_wins IRQ=%b exp=1", IRQ2_TIM); end
        drive(1'b1, 16'h0009, 1'b1, 8'h00, 5'b00000, 1'b0); tick();
        drive(1'b1, 16'h0008, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DI !== 8'h24 || IRQ2_TIM !== 1'b1) begin
            errors++; $display("FAIL set_unarmed DI=%h IRQ=%b exp=24/1", DI, IRQ2_TIM); end
        tick();
    endtask

    task automatic test_sci();
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 5'b00000, 1'b1); tick();
`ifdef HD63701_IRQ2_SCI_EN
        SCI_TDRE = 1'b0;
        drive(1'b1, 16'h0011, 1'b0, 8'h10, 5'b01000, 1'b0); tick();
        drive(1'b1, 16'h0011, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DI !== 8'h90 || IRQ2_SCI !== 1'b1) begin
            errors++; $display("FAIL rdrf_set DI=%h IRQ=%b exp=90/1", DI, IRQ2_SCI); end
        tick();
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 5'b00000, 1'b1); tick();
        drive(1'b0, 16'h0000, 1'b1, 8'h00, 5'b01000, 1'b0); tick();
        drive(1'b1, 16'h0012, 1'b1, 8'h00, 5'b00000, 1'b0); tick();
        drive(1'b1, 16'h0011, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DI !== 8'h80 || IRQ2_SCI !== 1'b0) begin
            errors++; $display("FAIL rst_disarm DI=%h IRQ=%b exp=80/0", DI, IRQ2_SCI); end
        tick();
`else
        SCI_TDRE = 1'b1;
        drive(1'b1, 16'h0011, 1'b0, 8'hFF, 5'b11000, 1'b0); tick();
        drive(1'b1, 16'h0011, 1'b1, 8'h00, 5'b00000, 1'b0);
        @(negedge CLKx2);
        checks++; if (DI !== 8'h20 || DSEL !== 1'b1 || IRQ2_SCI !== 1'b0) begin
            errors++; $display("FAIL sci_off DI=%h DSEL=%b IRQ=%b exp=20/1/0", DI, DSEL, IRQ2_SCI); end
        tick();
`endif
    endtask

    task automatic test_random();
        logic [15:0] addrs [10];
        logic [15:0] ad;
        logic [7:0]  exp_di;
        logic [4:0]  s;
        addrs = '{16'h0008, 16'h0009, 16'h000A, 16'h000B, 16'h000C,
                  16'h000D, 16'h0011, 16'h0012, 16'h0013, 16'h0008};
        for (int n = 0; n < 800; n++) begin
            ad = ($urandom_range(0, 15) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 9)];
            for (int b = 0; b < 5; b++) s[b] = ($urandom_range(0, 7) == 0);
            SCI_TDRE = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 3) != 0), ad, 1'($urandom_range(0, 2) != 0),
                  8'($urandom), s, $urandom_range(0, 60) == 0);
            @(negedge CLKx2);
            exp_di = (RW && AD == 16'h0008) ? exp_tcsr() : (RW && AD == 16'h0011) ? exp_trcsr() : 8'h00;
            checks++; if (DI !== exp_di || DSEL !== (RW && (AD == 16'h0008 || AD == 16'h0011))) begin
                errors++; $display("FAIL rnd_rd n=%0d ad=%h DI=%h exp=%h DSEL=%b", n, AD, DI, exp_di, DSEL); end
            checks++; if (IRQ2_TIM !== exp_irq_tim() || IRQ2_SCI !== exp_irq_sci()) begin
                errors++; $display("FAIL rnd_irq n=%0d tim=%b exp=%b sci=%b exp=%b",
                                   n, IRQ2_TIM, exp_irq_tim(), IRQ2_SCI, exp_irq_sci()); end
            tick();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_tcsr_write();
        test_ocf_clear();
        test_tof_icf();
        test_set_wins();
        test_sci();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
